nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: nibble-serial adder controller.
// One 4-bit adder slice is time-shared across NIBBLES nibbles, least
// significant nibble first. {Cout, Sum} = A + B + Cin, unsigned modulo 2^W.
// NIBBLES must be at least 2.
// Optional feature macro: OVERFLOW_FLAG_EN adds the Ovf port, the signed
// two's-complement overflow of the final result.
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Run,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Cout,
`ifdef OVERFLOW_FLAG_EN
    output logic                   Ovf,
`endif
    output logic                   Busy,
    output logic                   Done
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [3:0]      slice_sum;
    logic            slice_cout;

    // Shared 4-bit adder slice working on the current low operand nibbles.
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
    end

    // Control FSM with datapath registers and registered status outputs.
    // On the final ADD edge the operand registers' low nibbles still hold
    // the original top nibbles, so their bit 3 is the latched sign bit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            Sum   <= '0;
            Cout  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
`ifdef OVERFLOW_FLAG_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        Sum   <= '0;
                        Cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
                        Ovf   <= 1'b0;
`endif
                        Busy  <= 1'b1;
                        Done  <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    Sum   <= {slice_sum, Sum[W-1:4]};
                    carry <= slice_cout;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Cout  <= slice_cout;
`ifdef OVERFLOW_FLAG_EN
                        Ovf   <= (a_sh[3] == b_sh[3]) && (slice_sum[3] != a_sh[3]);
`endif
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        Done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl (NIBBLES=4). Expected results come
// from plain integer addition of the applied operands.
// Honors OVERFLOW_FLAG_EN the same way as the design.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 4 * NB;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Run = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Cin = 1'b0;
    logic [W-1:0]  Sum;
    logic          Cout;
    logic          Busy;
    logic          Done;
`ifdef OVERFLOW_FLAG_EN
    logic          Ovf;
`endif

    int checks = 0;
    int errors = 0;

    // expected result of the most recent operation
    logic [W-1:0]  exp_sum = '0;
    logic          exp_cout = 1'b0;
    logic          exp_ovf = 1'b0;

    nibble_serial_add_ctrl #(.NIBBLES(NB)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Run   (Run),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sum   (Sum),
        .Cout  (Cout),
`ifdef OVERFLOW_FLAG_EN
        .Ovf   (Ovf),
`endif
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width integer addition plus the signed-overflow rule.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
    endtask

    task automatic check_result(input string tag);
        check({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(Cout), 32'(exp_cout));
`ifdef OVERFLOW_FLAG_EN
        check({tag, "_ovf"}, 32'(Ovf), 32'(exp_ovf));
`endif
    endtask

    // Capture an operation, scramble the inputs afterwards, and wait for Done.
    // Counting the capture edge as edge 1, Done must appear on edge NB+1.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic keep_run);
        int n;
        model(a, b, c);
        A = a; B = b; Cin = c; Run = 1'b1;
        tick();
        Run = keep_run;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        check({tag, "_busy_start"}, 32'(Busy), 32'd1);
        check({tag, "_done_start"}, 32'(Done), 32'd0);
        n = 1;
        while (!Done && n < 4 * NB) begin
            tick();
            n++;
            if (!Done) check({tag, "_busy_mid"}, 32'(Busy), 32'd1);
        end
        check({tag, "_latency"}, 32'(n), 32'(NB + 1));
        check({tag, "_busy_done"}, 32'(Busy), 32'd0);
        check_result(tag);
    endtask

    initial begin
        // reset state
        tick(); tick();
        check("rst_sum", 32'(Sum), 32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
`ifdef OVERFLOW_FLAG_EN
        check("rst_ovf", 32'(Ovf), 32'd0);
`endif
        // reset overrides Run on the same edge
        Run = 1'b1; A = 16'h1111; B = 16'h2222;
        tick();
        check("rst_over_run", 32'(Busy), 32'd0);
        Reset = 1'b0; Run = 1'b0;
        tick();

        // directed cases
        run_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
        tick();
        check("idle_done", 32'(Done), 32'd0);
        check_result("idle_hold");

        run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        tick();
        run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();

        // Run held through DONE: result held, then a fresh operation
        run_op("hold", 16'h1234, 16'h4321, 1'b0, 1'b1);
        A = 16'h0001; B = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_done", 32'(Done), 32'd1);
            check_result("hold_res");
        end
        Run = 1'b0;
        tick();
        check("hold_exit", 32'(Done), 32'd0);
        check_result("hold_idle");
        run_op("after_hold", 16'h0001, 16'h0001, 1'b0, 1'b0);
        tick();

        // reset two edges into ADD aborts without Done
        A = 16'hABCD; B = 16'h1357; Run = 1'b1;
        tick();
        Run = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_sum", 32'(Sum), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_cout", 32'(Cout), 32'd0);
        for (int i = 0; i < 2 * NB; i++) begin
            tick();
            check("abort_nodone", 32'(Done), 32'd0);
        end
        run_op("post_rst", 16'h8000, 16'h8000, 1'b0, 1'b0);
        tick();

        // randomized operations
        for (int i = 0; i < 30; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            Run = 1'b0;
            tick();
            check("rand_idle", 32'(Done), 32'd0);
            check_result("rand_keep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
